// File: rtl/mil1553_rx_word.sv
// mil1553_rx_word: MIL-STD-1553 receive word decoder.
// Synchronizes the transceiver outputs, qualifies the 3-bit-time sync, decodes
// 16 Manchester-II data bits plus odd parity and holds the last good word.
`timescale 1ns / 1ps

module mil1553_rx_word #(
    parameter int unsigned FCLK_KHZ = 50000,
    parameter int unsigned BIT_KHZ  = 1000,
    parameter int unsigned SYNC_MIN = 66,
    parameter int unsigned SYNC_MAX = 84
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_p,
    input  logic        rx_n,
    output logic [15:0] dat,
    output logic [1:0]  dp_ptr,
    output logic        cmd,
    output logic        word_vld,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        busy
);

    localparam int unsigned T_BIT = FCLK_KHZ / BIT_KHZ;
    localparam int unsigned HALF  = T_BIT / 2;

    // Bit-timer landmarks
    localparam logic [6:0] T_SMP_A    = 7'(HALF / 2);
    localparam logic [6:0] T_SMP_B    = 7'(HALF + HALF / 2);
    localparam logic [6:0] T_LAST     = 7'(T_BIT - 1);
    localparam logic [6:0] T_SYNC_END = 7'(3 * HALF - 1);
    localparam logic [6:0] T_RS_LO    = 7'(HALF - 6);
    localparam logic [6:0] T_RS_HI    = 7'(HALF + 6);
    localparam logic [6:0] T_RS_SET   = 7'(HALF + 1);
    localparam logic [7:0] RUN_MIN    = 8'(SYNC_MIN);
    localparam logic [7:0] RUN_MAX    = 8'(SYNC_MAX);
    localparam logic [4:0] K_PAR      = 5'd16;

    localparam logic [2:0] ST_WAIT_IDLE = 3'd0;
    localparam logic [2:0] ST_IDLE      = 3'd1;
    localparam logic [2:0] ST_SYNC1     = 3'd2;
    localparam logic [2:0] ST_SYNC2     = 3'd3;
    localparam logic [2:0] ST_DATA      = 3'd4;

    // Line codes: H and L are bit-inverses of each other
    localparam logic [1:0] LN_IDLE = 2'b00;
    localparam logic [1:0] LN_H    = 2'b01;
    localparam logic [1:0] LN_L    = 2'b10;

    localparam logic [1:0] ERR_SYNC = 2'd1;
    localparam logic [1:0] ERR_MAN  = 2'd2;
    localparam logic [1:0] ERR_PAR  = 2'd3;

    logic        p_meta, p_sync, n_meta, n_sync;
    logic [1:0]  line, line_prev, pol_opp;

    logic [2:0]  state_q, state_d;
    logic [7:0]  run_q, run_d;
    logic [1:0]  pol_q, pol_d;
    logic        typ_q, typ_d;
    logic [6:0]  t_q, t_d;
    logic [4:0]  k_q, k_d;
    logic [1:0]  a_q, a_d;
    logic [15:0] sr_q, sr_d;
    logic        par_q, par_d;
    logic [15:0] dat_q, dat_d;
    logic        cmd_q, cmd_d;
    logic [1:0]  dp_ptr_q, dp_ptr_d;
    logic        word_vld_q, word_vld_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;

    logic        fail;
    logic [1:0]  fail_code;
    logic        bit_one;

    // Two-flop synchronizers plus previous line sample; left unreset so a
    // reset mid-word does not fake an idle line and restart decoding.
    always_ff @(posedge clk) begin
        p_meta    <= rx_p;
        p_sync    <= p_meta;
        n_meta    <= rx_n;
        n_sync    <= n_meta;
        line_prev <= line;
    end

    // Decode the synchronized pair into H / L / IDLE (both-high is IDLE)
    always_comb begin
        line = LN_IDLE;
        if (p_sync && !n_sync) begin
            line = LN_H;
        end else if (!p_sync && n_sync) begin
            line = LN_L;
        end
    end

    assign pol_opp = {pol_q[0], pol_q[1]};

    // Next-state logic for the sync/bit decoder and the held outputs
    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        pol_d      = pol_q;
        typ_d      = typ_q;
        t_d        = t_q;
        k_d        = k_q;
        a_d        = a_q;
        sr_d       = sr_q;
        par_d      = par_q;
        dat_d      = dat_q;
        cmd_d      = cmd_q;
        dp_ptr_d   = dp_ptr_q;
        word_vld_d = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        fail       = 1'b0;
        fail_code  = ERR_SYNC;
        bit_one    = (a_q == LN_H);

        case (state_q)
            ST_WAIT_IDLE: begin
                if (line == LN_IDLE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (line != LN_IDLE) begin
                    state_d = ST_SYNC1;
                    run_d   = 8'd1;
                    pol_d   = line;
                end
            end
            ST_SYNC1: begin
                if (line == pol_q) begin
                    if (run_q >= RUN_MAX) begin
                        fail = 1'b1;
                    end else begin
                        run_d = run_q + 8'd1;
                    end
                end else if (line == LN_IDLE || run_q < RUN_MIN) begin
                    fail = 1'b1;
                end else begin
                    state_d = ST_SYNC2;
                    typ_d   = (pol_q == LN_H);
                    t_d     = 7'd1;
                end
            end
            ST_SYNC2: begin
                t_d = t_q + 7'd1;
                if (t_q == T_SMP_B && line != pol_opp) begin
                    fail = 1'b1;
                end else if (t_q == T_SYNC_END) begin
                    state_d = ST_DATA;
                    t_d     = 7'd0;
                    k_d     = 5'd0;
                    par_d   = 1'b0;
                end
            end
            ST_DATA: begin
                t_d = t_q + 7'd1;
                // Mid-bit transition re-anchors the bit timer
                if (line != line_prev && t_q >= T_RS_LO && t_q <= T_RS_HI) begin
                    t_d = T_RS_SET;
                end
                if (t_q == T_SMP_A) begin
                    a_d = line;
                end
                if (t_q == T_SMP_B) begin
                    if (a_q == LN_IDLE || line == LN_IDLE || a_q == line) begin
                        fail      = 1'b1;
                        fail_code = ERR_MAN;
                    end else begin
                        par_d = par_q ^ bit_one;
                        if (k_q != K_PAR) begin
                            sr_d = {sr_q[14:0], bit_one};
                        end
                    end
                end
                if (t_q == T_LAST) begin
                    t_d = 7'd0;
                    if (k_q == K_PAR) begin
                        // This sample is still the parity bit's second half; IDLE
                        // picks up a following sync on the next sample.
                        state_d = ST_IDLE;
                        if (par_q) begin
                            dat_d      = sr_q;
                            cmd_d      = typ_q;
                            dp_ptr_d   = typ_q ? 2'd3 : 2'd0;
                            word_vld_d = 1'b1;
                        end else begin
                            err_d      = 1'b1;
                            err_code_d = ERR_PAR;
                        end
                    end else begin
                        k_d = k_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = ST_WAIT_IDLE;
            end
        endcase

        if (fail) begin
            state_d    = ST_WAIT_IDLE;
            err_d      = 1'b1;
            err_code_d = fail_code;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_WAIT_IDLE;
            run_q      <= 8'd0;
            pol_q      <= LN_IDLE;
            typ_q      <= 1'b0;
            t_q        <= 7'd0;
            k_q        <= 5'd0;
            a_q        <= LN_IDLE;
            sr_q       <= 16'd0;
            par_q      <= 1'b0;
            dat_q      <= 16'd0;
            cmd_q      <= 1'b0;
            dp_ptr_q   <= 2'd0;
            word_vld_q <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            pol_q      <= pol_d;
            typ_q      <= typ_d;
            t_q        <= t_d;
            k_q        <= k_d;
            a_q        <= a_d;
            sr_q       <= sr_d;
            par_q      <= par_d;
            dat_q      <= dat_d;
            cmd_q      <= cmd_d;
            dp_ptr_q   <= dp_ptr_d;
            word_vld_q <= word_vld_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign dat      = dat_q;
    assign cmd      = cmd_q;
    assign dp_ptr   = dp_ptr_q;
    assign word_vld = word_vld_q;
    assign err      = err_q;
    assign err_code = err_code_q;
    assign busy     = (state_q == ST_SYNC1) || (state_q == ST_SYNC2) || (state_q == ST_DATA);

endmodule
